// File: rtl/mult_arbiter.sv
// mult_arbiter: two-client round-robin front end for the shared 4x4 shift-add
// multiplier. It sequences start/operands, detects completion on the rising
// edge of done, and returns each result through a per-client response register.
// A watchdog aborts a job whose completion edge never arrives.
module mult_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_a,
  input  logic       req0_valid,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [7:0] rsp0_product,
  output logic       rsp0_err,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_product,
  output logic       rsp1_err,
  input  logic       rsp1_ready,
  output logic       mult_start,
  output logic [3:0] mult_dataa,
  output logic [3:0] mult_datab,
  input  logic       mult_done,
  input  logic [7:0] mult_product,
  output logic       busy,
  output logic       grant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Last wait-counter value before the job is declared dead.
  localparam logic [7:0] WCNT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic       grant_q, grant_d;
  logic [3:0] op_a_q, op_a_d;
  logic [3:0] op_b_q, op_b_d;
  logic       done_d_q;
  logic [7:0] wcnt_q, wcnt_d;
  logic       rsp0_valid_q, rsp0_valid_d;
  logic [7:0] rsp0_prod_q, rsp0_prod_d;
  logic       rsp0_err_q, rsp0_err_d;
  logic       rsp1_valid_q, rsp1_valid_d;
  logic [7:0] rsp1_prod_q, rsp1_prod_d;
  logic       rsp1_err_q, rsp1_err_d;

  logic       is_idle_s;
  logic       elig0_s, elig1_s;
  logic       win0_s, win1_s;
  logic       done_edge_s;

  // A client is eligible only while its response slot is empty; on a tie the
  // client that was not served last wins.
  assign is_idle_s   = (state_q == S_IDLE);
  assign elig0_s     = req0_valid & ~rsp0_valid_q;
  assign elig1_s     = req1_valid & ~rsp1_valid_q;
  assign win0_s      = elig0_s & (~elig1_s | last_q);
  assign win1_s      = elig1_s & (~elig0_s | ~last_q);
  assign done_edge_s = mult_done & ~done_d_q;

  assign req0_ready   = is_idle_s & win0_s;
  assign req1_ready   = is_idle_s & win1_s;
  assign mult_start   = (state_q == S_START);
  assign mult_dataa   = op_a_q;
  assign mult_datab   = op_b_q;
  assign busy         = ~is_idle_s;
  assign grant        = grant_q;
  assign rsp0_valid   = rsp0_valid_q;
  assign rsp0_product = rsp0_prod_q;
  assign rsp0_err     = rsp0_err_q;
  assign rsp1_valid   = rsp1_valid_q;
  assign rsp1_product = rsp1_prod_q;
  assign rsp1_err     = rsp1_err_q;

  // Next-state logic: arbitration, job sequencing, watchdog and response slots.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = grant_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    wcnt_d       = wcnt_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp0_prod_d  = rsp0_prod_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp1_prod_d  = rsp1_prod_q;
    rsp1_err_d   = rsp1_err_q;

    // Response handshakes; a load below takes precedence but cannot collide,
    // since a full slot blocks its client from being granted.
    if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end else begin
      rsp0_valid_d = rsp0_valid_q;
    end
    if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end else begin
      rsp1_valid_d = rsp1_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        if (req0_valid & req0_ready) begin
          op_a_d  = req0_a;
          op_b_d  = req0_b;
          grant_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_START;
        end else if (req1_valid & req1_ready) begin
          op_a_d  = req1_a;
          op_b_d  = req1_b;
          grant_d = 1'b1;
          last_d  = 1'b1;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        wcnt_d  = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_edge_s || (wcnt_q == WCNT_LAST)) begin
          state_d = S_IDLE;
          if (grant_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_prod_d  = done_edge_s ? mult_product : 8'd0;
            rsp1_err_d   = ~done_edge_s;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_prod_d  = done_edge_s ? mult_product : 8'd0;
            rsp0_err_d   = ~done_edge_s;
          end
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset returns everything to idle with client 0 favoured.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q      <= S_IDLE;
      last_q       <= 1'b1;
      grant_q      <= 1'b0;
      op_a_q       <= 4'd0;
      op_b_q       <= 4'd0;
      done_d_q     <= 1'b0;
      wcnt_q       <= 8'd0;
      rsp0_valid_q <= 1'b0;
      rsp0_prod_q  <= 8'd0;
      rsp0_err_q   <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp1_prod_q  <= 8'd0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      done_d_q     <= mult_done;
      wcnt_q       <= wcnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_prod_q  <= rsp0_prod_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_prod_q  <= rsp1_prod_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed test of mult_arbiter against a behavioural model of
// the 4-step multiplier (done rises 4 cycles after start drops and stays high
// until the next job, or never rises when hang is set).
module tb_mult_arbiter;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_a = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [7:0] rsp0_product, rsp1_product;
  logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic       mult_start;
  logic [3:0] mult_dataa, mult_datab;
  logic       mult_done = 1'b0;
  logic [7:0] mult_product = 8'd0;
  logic       busy, grant;

  bit         hang = 1'b0;
  int         mcnt = 0;
  logic [3:0] ma = 4'd0, mb = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;

  mult_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .reset_a(reset_a),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_product(rsp0_product), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_product(rsp1_product), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
    .mult_start(mult_start), .mult_dataa(mult_dataa), .mult_datab(mult_datab),
    .mult_done(mult_done), .mult_product(mult_product),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  // Multiplier model: done stays high through START and the first WAIT cycle
  // of the next job, then drops, and rises again D cycles after start drops.
  always @(posedge clk) begin
    if (mult_start) begin
      mcnt <= D;
      ma   <= mult_dataa;
      mb   <= mult_datab;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == D) mult_done <= 1'b0;
      if (mcnt == 1 && !hang) begin
        mult_done    <= 1'b1;
        mult_product <= 8'(ma) * 8'(mb);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic rspv(input int c);
    return (c != 0) ? rsp1_valid : rsp0_valid;
  endfunction

  // One job for client c from request to (optionally) taking the response.
  task automatic job(input int c, input logic [3:0] a, input logic [3:0] b,
                     input int exp_lat, input logic [7:0] exp_p, input logic exp_e,
                     input bit take);
    int n;
    @(negedge clk);
    if (c == 0) begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    else        begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    #1;
    check("req_ready", (c != 0) ? req1_ready : req0_ready, 1);
    @(negedge clk);
    if (c == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    check("start", mult_start, 1);
    check("grant", grant, c);
    check("dataa", mult_dataa, a);
    check("datab", mult_datab, b);
    @(negedge clk);
    check("start_one_cycle", mult_start, 0);
    check("busy_wait", busy, 1);
    check("dataa_stable", mult_dataa, a);
    n = 1;
    while (!rspv(c) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, exp_lat);
    check("product", (c != 0) ? rsp1_product : rsp0_product, exp_p);
    check("err", (c != 0) ? rsp1_err : rsp0_err, exp_e);
    check("idle_after", busy, 0);
    @(negedge clk);
    check("rsp_hold", rspv(c), 1);
    if (take) begin
      if (c == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      check("rsp_clear", rspv(c), 0);
    end
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_start", mult_start, 0);
    check("rst_dataa", mult_dataa, 0);
    check("rst_grant", grant, 0);
    check("rst_rsp0v", rsp0_valid, 0);
    check("rst_rsp1v", rsp1_valid, 0);
    check("rst_ready0", req0_ready, 0);
    reset_a = 1'b1;

    // Basic jobs; the second one sees stale done high through START
    job(0, 4'd3, 4'd5, D + 2, 8'd15, 1'b0, 1'b1);
    job(1, 4'd15, 4'd15, D + 2, 8'd225, 1'b0, 1'b1);

    // Both clients continuously valid: grants alternate 0,1,0,1
    @(negedge clk);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_a = 4'd2; req0_b = 4'd7; req1_a = 4'd6; req1_b = 4'd9;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!mult_start && n < 50) begin @(negedge clk); n++; end
      check("rr_start_seen", mult_start, 1);
      check("rr_grant", grant, i % 2);
      check("rr_dataa", mult_dataa, (i % 2 != 0) ? 6 : 2);
      n = 0;
      while (!rspv(i % 2) && n < 50) begin @(negedge clk); n++; end
      check("rr_product", (i % 2 != 0) ? rsp1_product : rsp0_product, (i % 2 != 0) ? 54 : 14);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);

    // Client 0 blocked by its unread response; client 1 still served
    job(0, 4'd4, 4'd4, D + 2, 8'd16, 1'b0, 1'b0);
    req0_a = 4'd5; req0_b = 4'd5; req0_valid = 1'b1;
    #1;
    check("blocked_ready0", req0_ready, 0);
    job(1, 4'd3, 4'd3, D + 2, 8'd9, 1'b0, 1'b1);
    check("still_blocked", req0_ready, 0);
    check("rsp0_held", rsp0_product, 16);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("freed_rsp0v", rsp0_valid, 0);
    check("freed_ready0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    check("freed_start", mult_start, 1);
    check("freed_dataa", mult_dataa, 5);
    n = 0;
    while (!rsp0_valid && n < 50) begin @(negedge clk); n++; end
    check("freed_product", rsp0_product, 25);
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;

    // Watchdog: no completion, then a normal job afterwards
    hang = 1'b1;
    job(0, 4'd2, 4'd2, 16, 8'd0, 1'b1, 1'b1);
    hang = 1'b0;
    job(1, 4'd7, 4'd3, D + 2, 8'd21, 1'b0, 1'b1);

    // Asynchronous reset mid-WAIT, then tie goes to client 0
    job(1, 4'd6, 4'd6, D + 2, 8'd36, 1'b0, 1'b0);
    @(negedge clk);
    req0_a = 4'd2; req0_b = 4'd9; req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    check("pre_rst_start", mult_start, 1);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #2 reset_a = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_start", mult_start, 0);
    check("arst_dataa", mult_dataa, 0);
    check("arst_datab", mult_datab, 0);
    check("arst_grant", grant, 0);
    check("arst_rsp1v", rsp1_valid, 0);
    check("arst_rsp1p", rsp1_product, 0);
    check("arst_ready0", req0_ready, 0);
    @(negedge clk);
    reset_a = 1'b1;
    req0_a = 4'd4; req0_b = 4'd4; req1_a = 4'd5; req1_b = 4'd5;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("tie_ready0", req0_ready, 1);
    check("tie_ready1", req1_ready, 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("tie_start", mult_start, 1);
    check("tie_grant", grant, 0);
    check("tie_dataa", mult_dataa, 4);
    n = 0;
    while (!rsp0_valid && n < 50) begin @(negedge clk); n++; end
    check("tie_product", rsp0_product, 16);
    check("tie_err", rsp0_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
